// File: rtl/demux_1to2_buf.sv
// Buffered 1-to-2 demultiplexer: one valid/ready input stream steered by select_i
// into two independent per-channel FIFOs, each with its own valid/ready output.
module demux_1to2_buf #(
    parameter  int size  = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [size-1:0] data_i,
    input  logic            select_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [size-1:0] data0_o,
    output logic            valid0_o,
    input  logic            ready0_i,
    output logic [size-1:0] data1_o,
    output logic            valid1_o,
    input  logic            ready1_i,
    output logic [CW-1:0]   count0_o,
    output logic [CW-1:0]   count1_o
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]      w_full;
    logic [1:0]      w_push;
    logic [1:0]      w_pop;
    logic [1:0]      w_consumer_rdy;
    logic [size-1:0] w_head  [2];
    logic [CW-1:0]   w_count [2];

    assign w_consumer_rdy = {ready1_i, ready0_i};

    // Acceptance depends only on registered counts and select_i, never on the consumers.
    assign ready_o = select_i ? ~w_full[1] : ~w_full[0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [size-1:0] r_mem [DEPTH];
            logic [AW-1:0]   r_wr_ptr;
            logic [AW-1:0]   r_rd_ptr;
            logic [CW-1:0]   r_count;

            assign w_full[gi] = (r_count == CW'(DEPTH));
            assign w_push[gi] = valid_i && ready_o && (select_i == 1'(gi));
            assign w_pop[gi]  = (r_count != '0) && w_consumer_rdy[gi];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_mem[i] <= '0;
                    end
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[gi]) begin
                        r_mem[r_wr_ptr] <= data_i;
                        r_wr_ptr        <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop[gi]) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            // Head is read straight from storage; pointers wrap naturally at power-of-two DEPTH.
            assign w_head[gi]  = r_mem[r_rd_ptr];
            assign w_count[gi] = r_count;
        end
    endgenerate

    assign data0_o  = w_head[0];
    assign data1_o  = w_head[1];
    assign count0_o = w_count[0];
    assign count1_o = w_count[1];
    assign valid0_o = (w_count[0] != '0);
    assign valid1_o = (w_count[1] != '0);

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Bench for demux_1to2_buf: hand-derived vector table plus a queue scoreboard
// checked every cycle, an async-reset corner and a random traffic phase.
module tb_demux_1to2_buf;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [W-1:0]  data_i;
    logic          select_i;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  data0_o;
    logic          valid0_o;
    logic          ready0_i;
    logic [W-1:0]  data1_o;
    logic          valid1_o;
    logic          ready1_i;
    logic [CW-1:0] count0_o;
    logic [CW-1:0] count1_o;

    demux_1to2_buf #(.size(W), .DEPTH(DEPTH)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .select_i (select_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data0_o  (data0_o),
        .valid0_o (valid0_o),
        .ready0_i (ready0_i),
        .data1_o  (data1_o),
        .valid1_o (valid1_o),
        .ready1_i (ready1_i),
        .count0_o (count0_o),
        .count1_o (count1_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    typedef struct {
        logic         v;
        logic         s;
        logic [W-1:0] d;
        logic         r0;
        logic         r1;
        logic         erdy;
        int           ec0;
        int           ec1;
        logic [W-1:0] ed0;
        logic [W-1:0] ed1;
    } vec_t;

    vec_t vec[24];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic v, input logic s, input logic [W-1:0] d,
                         input logic r0, input logic r1);
        @(negedge clk_i);
        valid_i  = v;
        select_i = s;
        data_i   = d;
        ready0_i = r0;
        ready1_i = r1;
        #1;
    endtask

    // Compare against the scoreboard queues, then advance one edge and update them.
    task automatic step();
        logic exp_rdy, acc, p0, p1;
        logic [W-1:0] got0, got1;
        chk("sb_count0", W'(count0_o), W'(q0.size()));
        chk("sb_count1", W'(count1_o), W'(q1.size()));
        chk("sb_valid0", W'(valid0_o), W'(q0.size() != 0));
        chk("sb_valid1", W'(valid1_o), W'(q1.size() != 0));
        exp_rdy = select_i ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
        chk("sb_ready", W'(ready_o), W'(exp_rdy));
        acc  = valid_i && exp_rdy;
        p0   = (q0.size() != 0) && ready0_i;
        p1   = (q1.size() != 0) && ready1_i;
        got0 = data0_o;
        got1 = data1_o;
        if (p0) chk("sb_data0", got0, q0[0]);
        if (p1) chk("sb_data1", got1, q1[0]);
        @(posedge clk_i);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (select_i) q1.push_back(data_i);
            else          q0.push_back(data_i);
        end
        if (acc || p0 || p1)
            $display("t=%0t push=%0b sel=%0b din=%0h pop0=%0b d0=%0h pop1=%0b d1=%0h",
                     $time, acc, select_i, data_i, p0, got0, p1, got1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // v s data r0 r1 | pre-edge: ready count0 count1 head0 head1
        vec[0]  = '{1, 0, 32'hA5, 0, 0, 1, 0, 0, 32'h00, 32'h00};
        vec[1]  = '{1, 1, 32'h11, 0, 0, 1, 1, 0, 32'hA5, 32'h00};
        vec[2]  = '{1, 1, 32'h22, 0, 0, 1, 1, 1, 32'hA5, 32'h11};
        vec[3]  = '{1, 1, 32'h33, 0, 0, 1, 1, 2, 32'hA5, 32'h11};
        vec[4]  = '{1, 1, 32'h44, 0, 0, 1, 1, 3, 32'hA5, 32'h11};
        vec[5]  = '{1, 1, 32'h77, 0, 0, 0, 1, 4, 32'hA5, 32'h11};
        vec[6]  = '{1, 0, 32'h55, 0, 0, 1, 1, 4, 32'hA5, 32'h11};
        vec[7]  = '{1, 1, 32'h66, 0, 1, 0, 2, 4, 32'hA5, 32'h11};
        vec[8]  = '{1, 1, 32'h66, 0, 1, 1, 2, 3, 32'hA5, 32'h22};
        vec[9]  = '{0, 1, 32'h00, 0, 1, 1, 2, 3, 32'hA5, 32'h33};
        vec[10] = '{0, 1, 32'h00, 0, 1, 1, 2, 2, 32'hA5, 32'h44};
        vec[11] = '{0, 1, 32'h00, 0, 1, 1, 2, 1, 32'hA5, 32'h66};
        vec[12] = '{0, 1, 32'h00, 0, 0, 1, 2, 0, 32'hA5, 32'h22};
        vec[13] = '{1, 0, 32'h56, 0, 0, 1, 2, 0, 32'hA5, 32'h22};
        vec[14] = '{1, 0, 32'h57, 0, 0, 1, 3, 0, 32'hA5, 32'h22};
        vec[15] = '{1, 0, 32'h58, 1, 0, 0, 4, 0, 32'hA5, 32'h22};
        vec[16] = '{1, 0, 32'h58, 1, 0, 1, 3, 0, 32'h55, 32'h22};
        vec[17] = '{0, 0, 32'h00, 0, 0, 1, 3, 0, 32'h56, 32'h22};
        vec[18] = '{1, 0, 32'hA0, 1, 1, 1, 0, 0, 32'h00, 32'h00};
        vec[19] = '{1, 1, 32'hA1, 1, 1, 1, 1, 0, 32'hA0, 32'h00};
        vec[20] = '{1, 0, 32'hA2, 1, 1, 1, 0, 1, 32'h00, 32'hA1};
        vec[21] = '{1, 1, 32'hA3, 1, 1, 1, 1, 0, 32'hA2, 32'h00};
        vec[22] = '{0, 0, 32'h00, 1, 1, 1, 0, 1, 32'h00, 32'hA3};
        vec[23] = '{0, 0, 32'h00, 0, 0, 1, 0, 0, 32'h00, 32'h00};

        rst_i    = 1'b1;
        valid_i  = 1'b0;
        select_i = 1'b0;
        data_i   = '0;
        ready0_i = 1'b0;
        ready1_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", W'(ready_o), W'(1));
        chk("rst_valid0", W'(valid0_o), W'(0));
        chk("rst_valid1", W'(valid1_o), W'(0));
        chk("rst_count0", W'(count0_o), W'(0));
        chk("rst_count1", W'(count1_o), W'(0));
        chk("rst_data0", data0_o, W'(0));
        chk("rst_data1", data1_o, W'(0));
        rst_i = 1'b0;

        for (int i = 0; i < 24; i++) begin
            if (i == 18) begin
                // Asynchronous reset pulse between edges while channel 0 holds three words.
                @(negedge clk_i);
                valid_i  = 1'b0;
                ready0_i = 1'b0;
                ready1_i = 1'b0;
                #1 rst_i = 1'b1;
                #1;
                chk("arst_valid0", W'(valid0_o), W'(0));
                chk("arst_count0", W'(count0_o), W'(0));
                chk("arst_data0", data0_o, W'(0));
                chk("arst_ready", W'(ready_o), W'(1));
                #1 rst_i = 1'b0;
                q0.delete();
                q1.delete();
            end
            apply(vec[i].v, vec[i].s, vec[i].d, vec[i].r0, vec[i].r1);
            chk($sformatf("vec%0d_ready", i), W'(ready_o), W'(vec[i].erdy));
            chk($sformatf("vec%0d_count0", i), W'(count0_o), W'(vec[i].ec0));
            chk($sformatf("vec%0d_count1", i), W'(count1_o), W'(vec[i].ec1));
            chk($sformatf("vec%0d_data0", i), data0_o, vec[i].ed0);
            chk($sformatf("vec%0d_data1", i), data1_o, vec[i].ed1);
            step();
        end

        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
            step();
        end
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            apply(1'b0, 1'b0, '0, 1'b1, 1'b1);
            step();
        end
        chk("final_count0", W'(count0_o), W'(0));
        chk("final_count1", W'(count1_o), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
